// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller: debounced request latch plus DW/WALK/FLASH sequencer.
// Optional audible chirp during WALK is enabled by defining PED_CHIRP_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_DW    | steady DONT_WALK, waiting for window start with a request
// S_WALK  | WALK lamp on, remain counting down through the walk phase
// S_FLASH | DONT_WALK flashing, remain counting down to zero
module ped_crossing_ctrl #(
    parameter int DEBOUNCE_CYC = 3,
    parameter int WALK_CYC     = 3,
    parameter int FLASH_CYC    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ped_btn,
    input  logic [2:0] NS,
    input  logic [2:0] EW,
    output logic       walk,
    output logic       dont_walk,
    output logic       req_pending,
    output logic [3:0] remain,
    output logic       chirp
);

    localparam int              CW        = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0]   DEB_MAX   = CW'(DEBOUNCE_CYC);
    localparam logic [3:0]      TOTAL     = 4'(WALK_CYC + FLASH_CYC);
    localparam logic [3:0]      WALK_LAST = 4'(FLASH_CYC + 1);
    localparam logic            FLASH_ODD = (FLASH_CYC % 2) == 1;

    typedef enum logic [1:0] {
        S_DW    = 2'd0,
        S_WALK  = 2'd1,
        S_FLASH = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [3:0]    remain_nxt;
    logic          sync_ff1, btn_sync;
    logic [CW-1:0] deb_cnt;
    logic          win_q;
    logic          window;
    logic          qualify;
    logic          start;

    assign window  = (NS == 3'b100) && (EW == 3'b001);
    // Qualify exactly once: the count saturates at DEB_MAX, so a held button never re-hits DEB_MAX-1.
    assign qualify = btn_sync && (deb_cnt == DEB_MAX - 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff1    <= 1'b0;
            btn_sync    <= 1'b0;
            deb_cnt     <= '0;
            win_q       <= 1'b0;
            req_pending <= 1'b0;
        end else begin
            sync_ff1 <= ped_btn;
            btn_sync <= sync_ff1;
            win_q    <= window;
            if (!btn_sync)
                deb_cnt <= '0;
            else if (deb_cnt != DEB_MAX)
                deb_cnt <= deb_cnt + 1'b1;
            // A qualification in the same cycle as WALK entry wins over the clear.
            if (qualify)
                req_pending <= 1'b1;
            else if (start)
                req_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_DW;
            remain <= 4'd0;
        end else begin
            state  <= state_nxt;
            remain <= remain_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        remain_nxt = remain;
        start      = 1'b0;
        case (state)
            S_DW: begin
                remain_nxt = 4'd0;
                if (window && !win_q && req_pending) begin
                    state_nxt  = S_WALK;
                    remain_nxt = TOTAL;
                    start      = 1'b1;
                end
            end
            S_WALK: begin
                if (!window) begin
                    state_nxt  = S_DW;
                    remain_nxt = 4'd0;
                end else begin
                    remain_nxt = remain - 1'b1;
                    if (remain == WALK_LAST)
                        state_nxt = (FLASH_CYC == 0) ? S_DW : S_FLASH;
                end
            end
            S_FLASH: begin
                if (!window || remain == 4'd1) begin
                    state_nxt  = S_DW;
                    remain_nxt = 4'd0;
                end else begin
                    remain_nxt = remain - 1'b1;
                end
            end
            default: begin
                state_nxt  = S_DW;
                remain_nxt = 4'd0;
            end
        endcase
    end

    // FLASH phase parity comes from remain: first flash cycle has remain == FLASH_CYC.
    always_comb begin
        walk      = 1'b0;
        dont_walk = 1'b1;
        case (state)
            S_WALK: begin
                walk      = 1'b1;
                dont_walk = 1'b0;
            end
            S_FLASH: dont_walk = ~(remain[0] ^ FLASH_ODD);
            default: ;
        endcase
    end

`ifdef PED_CHIRP_EN
    localparam logic TOTAL_ODD = ((WALK_CYC + FLASH_CYC) % 2) == 1;

    always_comb begin
        chirp = (state == S_WALK) && ~(remain[0] ^ TOTAL_ODD);
    end
`else
    assign chirp = 1'b0;
`endif

endmodule
